// File: rtl/matrix_cfg_pkg.sv
// matrix_cfg_pkg: shared constants and types for the switch-box configuration loader.
// Rev 1.0
`default_nettype none

package matrix_cfg_pkg;

    localparam logic [7:0] SYNC_WORD = 8'hA5;
    localparam int         N_TB      = 5;
    localparam int         N_LR      = 4;
    localparam int         W         = 6;
    localparam int         N_WORDS   = 18;
    localparam int         CKSUM_W   = 6;

    localparam logic [2:0] SIDE_NONE   = 3'd0;
    localparam logic [2:0] SIDE_TOP    = 3'd1;
    localparam logic [2:0] SIDE_RIGHT  = 3'd2;
    localparam logic [2:0] SIDE_BOTTOM = 3'd3;
    localparam logic [2:0] SIDE_LEFT   = 3'd4;

    localparam logic [2:0] MAX_TB_IDX = 3'(N_TB - 1);
    localparam logic [2:0] MAX_LR_IDX = 3'(N_LR - 1);

    localparam logic [1:0] ERR_NONE  = 2'b00;
    localparam logic [1:0] ERR_CKSUM = 2'b01;
    localparam logic [1:0] ERR_RANGE = 2'b10;
    localparam logic [1:0] ERR_BOTH  = 2'b11;

    typedef enum logic [1:0] {
        ST_HUNT   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_CHECK  = 2'd2,
        ST_COMMIT = 2'd3
    } state_e;

endpackage

`default_nettype wire

// File: rtl/cfg_word_check.sv
// cfg_word_check: flags a routing-select word whose pin index exceeds its side's pin count.
// Rev 1.0
`default_nettype none

module cfg_word_check
    import matrix_cfg_pkg::*;
(
    input  logic [W-1:0] word_i,
    output logic         illegal_o
);

    logic [2:0] side;
    logic [2:0] idx;

    assign side = word_i[2:0];
    assign idx  = word_i[W-1:3];

    // Codes outside 1..4 drive high-Z, so their index is irrelevant.
    always_comb begin
        illegal_o = 1'b0;
        case (side)
            SIDE_TOP, SIDE_BOTTOM: illegal_o = (idx > MAX_TB_IDX);
            SIDE_RIGHT, SIDE_LEFT: illegal_o = (idx > MAX_LR_IDX);
            default:               illegal_o = 1'b0;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/matrix_cfg_loader.sv
// matrix_cfg_loader: framed bit-serial loader that validates and atomically commits 18 route selects.
// Rev 1.0
`default_nettype none

module matrix_cfg_loader
    import matrix_cfg_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_bit_i,
    input  logic              cfg_valid_i,
    output logic              cfg_ready_o,
    output logic [N_TB*W-1:0] cfg_top_o,
    output logic [N_TB*W-1:0] cfg_bottom_o,
    output logic [N_LR*W-1:0] cfg_left_o,
    output logic [N_LR*W-1:0] cfg_right_o,
    output logic              cfg_busy_o,
    output logic              cfg_done_o,
    output logic              cfg_err_o,
    output logic [1:0]        err_code_o
);

    state_e       state_q;
    logic [7:0]   sync_q;
    logic [2:0]   bit_cnt_q;
    logic [4:0]   word_cnt_q;
    logic [W-1:0] word_q;
    logic [W-1:0] xor_q;
    logic         range_q;
    logic [W-1:0] shadow_q [N_WORDS];
    logic [W-1:0] active_q [N_WORDS];
    logic         done_q;
    logic         err_q;
    logic [1:0]   err_code_q;

    logic         accept;
    logic [7:0]   sync_d;
    logic [W-1:0] word_d;
    logic         word_illegal;

    assign cfg_ready_o = (state_q != ST_COMMIT);
    assign cfg_busy_o  = (state_q != ST_HUNT);
    assign accept      = cfg_valid_i && cfg_ready_o;
    assign sync_d      = {sync_q[6:0], cfg_bit_i};
    assign word_d      = {word_q[W-2:0], cfg_bit_i};

    cfg_word_check u_word_check (
        .word_i    (word_d),
        .illegal_o (word_illegal)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_HUNT;
            sync_q     <= '0;
            bit_cnt_q  <= '0;
            word_cnt_q <= '0;
            word_q     <= '0;
            xor_q      <= '0;
            range_q    <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            err_code_q <= ERR_NONE;
            for (int i = 0; i < N_WORDS; i++) begin
                shadow_q[i] <= '0;
                active_q[i] <= '0;
            end
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state_q)
                ST_HUNT: begin
                    if (accept) begin
                        sync_q <= sync_d;
                        // Clearing the pattern keeps stale bits from forming a false match next hunt.
                        if (sync_d == SYNC_WORD) begin
                            state_q    <= ST_LOAD;
                            sync_q     <= '0;
                            bit_cnt_q  <= '0;
                            word_cnt_q <= '0;
                            xor_q      <= '0;
                            range_q    <= 1'b0;
                        end
                    end
                end
                ST_LOAD: begin
                    if (accept) begin
                        word_q <= word_d;
                        if (bit_cnt_q == 3'(W - 1)) begin
                            bit_cnt_q            <= '0;
                            shadow_q[word_cnt_q] <= word_d;
                            xor_q                <= xor_q ^ word_d;
                            range_q              <= range_q | word_illegal;
                            if (word_cnt_q == 5'(N_WORDS - 1)) begin
                                state_q <= ST_CHECK;
                            end else begin
                                word_cnt_q <= word_cnt_q + 5'd1;
                            end
                        end else begin
                            bit_cnt_q <= bit_cnt_q + 3'd1;
                        end
                    end
                end
                ST_CHECK: begin
                    if (accept) begin
                        word_q <= word_d;
                        if (bit_cnt_q == 3'(CKSUM_W - 1)) begin
                            bit_cnt_q <= '0;
                            state_q   <= ST_COMMIT;
                        end else begin
                            bit_cnt_q <= bit_cnt_q + 3'd1;
                        end
                    end
                end
                ST_COMMIT: begin
                    if ((word_q == xor_q) && !range_q) begin
                        for (int i = 0; i < N_WORDS; i++) begin
                            active_q[i] <= shadow_q[i];
                        end
                        done_q     <= 1'b1;
                        err_code_q <= ERR_NONE;
                    end else begin
                        err_q      <= 1'b1;
                        err_code_q <= {range_q, (word_q != xor_q)};
                    end
                    state_q <= ST_HUNT;
                end
                default: state_q <= ST_HUNT;
            endcase
        end
    end

    assign cfg_done_o = done_q;
    assign cfg_err_o  = err_q;
    assign err_code_o = err_code_q;

    for (genvar i = 0; i < N_TB; i++) begin : g_tb_out
        assign cfg_top_o[i*W +: W]    = active_q[i];
        assign cfg_bottom_o[i*W +: W] = active_q[N_TB + i];
    end

    for (genvar i = 0; i < N_LR; i++) begin : g_lr_out
        assign cfg_left_o[i*W +: W]  = active_q[2*N_TB + i];
        assign cfg_right_o[i*W +: W] = active_q[2*N_TB + N_LR + i];
    end

endmodule

`default_nettype wire
